// File: rtl/exec_mul_ctrl.sv
// Iterative 16x16 shift-and-add multiplier controller with stall/flush handshake to the pipeline.
// Optional build macro EXEC_MUL_EARLY_TERM_EN ends RUN once the remaining multiplier bits are all zero.
module exec_mul_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [15:0] result,
  output logic        ovf,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  logic [31:0] r_acc;
  logic [31:0] r_mcand;
  logic [15:0] r_mplier;
  logic [3:0]  r_count;
  logic [15:0] r_result;
  logic        r_ovf;
  logic        r_err;

  logic        w_accept;
  logic [31:0] w_acc_next;
  logic [15:0] w_mplier_next;
  logic        w_last;

  assign w_accept      = (r_state == S_IDLE) && start && !flush;
  assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_next = r_mplier >> 1;

`ifdef EXEC_MUL_EARLY_TERM_EN
  // Once no multiplier bits remain, further iterations cannot change the sum.
  assign w_last = (r_count == 4'd15) || (w_mplier_next == 16'd0);
`else
  assign w_last = (r_count == 4'd15);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_acc    <= 32'd0;
      r_mcand  <= 32'd0;
      r_mplier <= 16'd0;
      r_count  <= 4'd0;
      r_result <= 16'd0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= start && !flush && (r_state != S_IDLE);
      if (flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_mcand  <= {16'd0, op_a};
              r_mplier <= op_b;
              r_acc    <= 32'd0;
              r_count  <= 4'd0;
              r_state  <= S_RUN;
            end
          end
          S_RUN: begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_next;
            r_count  <= r_count + 4'd1;
            // Result is captured on entry to DONE so it is valid alongside the done pulse.
            if (w_last) begin
              r_state  <= S_DONE;
              r_result <= w_acc_next[15:0];
              r_ovf    <= |w_acc_next[31:16];
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign stall  = busy || w_accept;
  assign result = r_result;
  assign ovf    = r_ovf;
  assign err    = r_err;

endmodule
